// File: rtl/shift_4094_loader.sv
// Serialises a parallel word MSB-first into a daisy-chained 4094 shift/latch chain,
// then strobes it into the output latches and enables the outputs after the first load.
module shift_4094_loader #(
    parameter int N_BYTES = 3,
    parameter int CLK_DIV = 4
) (
    input  logic                   CLK,
    input  logic                   _RST,
    input  logic                   start,
    input  logic [8*N_BYTES-1:0]   data,
    input  logic                   oe_off,
    output logic                   busy,
    output logic                   done,
    output logic                   _4094_CLK,
    output logic                   _4094_DATA,
    output logic                   _4094_STROBE,
    output logic                   _4094_OE_CTL
);

    localparam int W  = 8 * N_BYTES;
    localparam int PW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(W) + 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SHIFT_LO = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_STROBE   = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    localparam logic [PW-1:0] PH_LOAD = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] PH_ZERO = PW'(0);
    localparam logic [BW-1:0] BIT_LOAD = BW'(W);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_ZERO = BW'(0);

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] bits_q, bits_d;
    logic [W-1:0]  sreg_q, sreg_d;
    logic          armed_q, armed_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sclk_q, sclk_d;
    logic          sdat_q, sdat_d;
    logic          stb_q, stb_d;
    logic          oe_q, oe_d;

    // Next-state logic: each timed state runs its phase counter down from CLK_DIV-1 to zero.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bits_d  = bits_q;
        sreg_d  = sreg_q;
        armed_d = armed_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sreg_d  = data;
                    bits_d  = BIT_LOAD;
                    phase_d = PH_LOAD;
                    state_d = ST_SHIFT_LO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_q == PH_ZERO) begin
                    phase_d = PH_LOAD;
                    state_d = ST_SHIFT_HI;
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_q == PH_ZERO) begin
                    sreg_d  = {sreg_q[W-2:0], 1'b0};
                    bits_d  = bits_q - BIT_ONE;
                    phase_d = PH_LOAD;
                    state_d = (bits_q == BIT_ONE) ? ST_STROBE : ST_SHIFT_LO;
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end
            ST_STROBE: begin
                if (phase_q == PH_ZERO) begin
                    state_d = ST_FINISH;
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end
            ST_FINISH: begin
                armed_d = 1'b1;
                if (start) begin
                    sreg_d  = data;
                    bits_d  = BIT_LOAD;
                    phase_d = PH_LOAD;
                    state_d = ST_SHIFT_LO;
                end else begin
                    phase_d = PH_ZERO;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                phase_d = PH_ZERO;
                bits_d  = BIT_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        busy_d = (state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI) || (state_d == ST_STROBE);
        done_d = (state_d == ST_FINISH);
        sclk_d = (state_d == ST_SHIFT_HI);
        stb_d  = (state_d == ST_STROBE);
        oe_d   = armed_d & ~oe_off;
        case (state_d)
            ST_SHIFT_LO: sdat_d = sreg_d[W-1];
            ST_SHIFT_HI: sdat_d = sdat_q;
            ST_STROBE:   sdat_d = sdat_q;
            default:     sdat_d = 1'b0;
        endcase
    end

    // State and output registers, cleared asynchronously so a load is aborted without a strobe.
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q <= ST_IDLE;
            phase_q <= PH_ZERO;
            bits_q  <= BIT_ZERO;
            sreg_q  <= {W{1'b0}};
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdat_q  <= 1'b0;
            stb_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bits_q  <= bits_d;
            sreg_q  <= sreg_d;
            armed_q <= armed_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            sdat_q  <= sdat_d;
            stb_q   <= stb_d;
            oe_q    <= oe_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign _4094_CLK    = sclk_q;
    assign _4094_DATA   = sdat_q;
    assign _4094_STROBE = stb_q;
    assign _4094_OE_CTL = oe_q;

endmodule

// File: tb/tb_shift_4094_loader.sv
// Randomised bench: two loaders (CLK_DIV=4 and CLK_DIV=1) share stimulus and are compared
// every cycle against a timeline model derived from the load's cycle offset.
module tb_shift_4094_loader;

    localparam int NB = 3;
    localparam int W  = 8 * NB;

    logic          CLK = 1'b0;
    logic          _RST = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  data = '0;
    logic          oe_off = 1'b0;

    logic busy_a, done_a, sclk_a, sdat_a, stb_a, oe_a;
    logic busy_b, done_b, sclk_b, sdat_b, stb_b, oe_b;

    int errors = 0;
    int checks = 0;

    int           m_k[2];
    logic [W-1:0] m_word[2];
    logic         m_armed[2];
    logic         m_oe[2];

    shift_4094_loader #(.N_BYTES(NB), .CLK_DIV(4)) dut (
        .CLK(CLK), ._RST(_RST), .start(start), .data(data), .oe_off(oe_off),
        .busy(busy_a), .done(done_a), ._4094_CLK(sclk_a), ._4094_DATA(sdat_a),
        ._4094_STROBE(stb_a), ._4094_OE_CTL(oe_a)
    );

    shift_4094_loader #(.N_BYTES(NB), .CLK_DIV(1)) dut_div1 (
        .CLK(CLK), ._RST(_RST), .start(start), .data(data), .oe_off(oe_off),
        .busy(busy_b), .done(done_b), ._4094_CLK(sclk_b), ._4094_DATA(sdat_b),
        ._4094_STROBE(stb_b), ._4094_OE_CTL(oe_b)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Expected {busy,done,clk,strobe,oe} for a cycle k cycles after acceptance.
    function automatic logic [4:0] exp_vec(input int k, input int d, input logic oe);
        int  sh;
        int  len;
        logic b, dn, c, s;
        sh  = 2 * d * W;
        len = sh + d;
        b   = (k >= 1) && (k <= len);
        dn  = (k == len + 1);
        c   = (k >= 1) && (k <= sh) && ((((k - 1) / d) % 2) == 1);
        s   = (k > sh) && (k <= len);
        return {b, dn, c, s, oe};
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int len;
            len = 2 * div_of(i) * W + div_of(i);
            if (!_RST) begin
                m_k[i] = 0;
                m_armed[i] = 1'b0;
                m_oe[i] = 1'b0;
            end else begin
                if (m_k[i] == len + 1) m_armed[i] = 1'b1;
                if (((m_k[i] == 0) || (m_k[i] == len + 1)) && start) begin
                    m_k[i] = 1;
                    m_word[i] = data;
                end else if ((m_k[i] != 0) && (m_k[i] <= len)) begin
                    m_k[i] = m_k[i] + 1;
                end else begin
                    m_k[i] = 0;
                end
                m_oe[i] = m_armed[i] & ~oe_off;
            end
        end
    endtask

    task automatic check_outputs();
        logic [4:0] obs[2];
        logic       sd[2];
        obs[0] = {busy_a, done_a, sclk_a, stb_a, oe_a};
        obs[1] = {busy_b, done_b, sclk_b, stb_b, oe_b};
        sd[0] = sdat_a;
        sd[1] = sdat_b;
        for (int i = 0; i < 2; i++) begin
            int d;
            d = div_of(i);
            check_eq((i == 0) ? "ctl_div4" : "ctl_div1", 32'(obs[i]), 32'(exp_vec(m_k[i], d, m_oe[i])));
            if ((m_k[i] >= 1) && (m_k[i] <= 2 * d * W))
                check_eq((i == 0) ? "sdata_div4" : "sdata_div1", 32'(sd[i]),
                         32'(m_word[i][W - 1 - ((m_k[i] - 1) / (2 * d))]));
        end
    endtask

    task automatic step(input logic st, input logic [W-1:0] dt, input logic off);
        start  = st;
        data   = dt;
        oe_off = off;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_outputs();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            m_k[i] = 0; m_word[i] = '0; m_armed[i] = 1'b0; m_oe[i] = 1'b0;
        end
        repeat (3) @(negedge CLK);
        check_outputs();
        _RST = 1'b1;

        // Directed load from the first edge after reset; data scrambled while busy.
        step(1'b1, 24'hA50F81, 1'b0);
        for (int c = 0; c < 205; c++) step(1'b0, W'($urandom), 1'b0);

        // Output-enable override after arming, no reload.
        for (int c = 0; c < 4; c++) step(1'b0, W'($urandom), 1'b1);
        for (int c = 0; c < 4; c++) step(1'b0, W'($urandom), 1'b0);

        // start held high: back-to-back loads.
        for (int c = 0; c < 450; c++) step(1'b1, W'($urandom), 1'b0);

        // Random traffic including start pulses while busy.
        for (int c = 0; c < 1500; c++)
            step($urandom_range(0, 15) == 0, W'($urandom), $urandom_range(0, 31) == 0);

        // All-ones word once both loaders are idle.
        n = 0;
        while (((m_k[0] != 0) || (m_k[1] != 0)) && (n < 300)) begin
            step(1'b0, W'($urandom), 1'b0);
            n++;
        end
        check_eq("idle_bound", 32'(n < 300), 32'd1);
        step(1'b1, 24'hFFFFFF, 1'b0);
        for (int c = 0; c < 200; c++) step(1'b0, W'($urandom), 1'b0);

        // Reset in the middle of a load.
        step(1'b1, W'($urandom), 1'b0);
        for (int c = 0; c < 99; c++) step(1'b0, W'($urandom), 1'b0);
        #1 _RST = 1'b0;
        #1 check_eq("rst_async", 32'({busy_a, done_a, sclk_a, sdat_a, stb_a, oe_a,
                                       busy_b, done_b, sclk_b, sdat_b, stb_b, oe_b}), 32'd0);
        step(1'b1, W'($urandom), 1'b0);
        _RST = 1'b1;
        for (int c = 0; c < 20; c++) step(1'b0, W'($urandom), 1'b0);
        step(1'b1, W'($urandom), 1'b0);
        for (int c = 0; c < 205; c++) step(1'b0, W'($urandom), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
